// File: rtl/video_axiw_arb_if.sv
// ----------------------------------------------------------------------------
// video_axiw_arb_if
//  AXI4 write-channel bundle (AW, W and B channels, 512-bit data) shared by the
//  video write controllers, the write arbiter and the MIG AXI slot.
//  Modports:
//    master : drives AW/W and BREADY (burst initiator side)
//    slave  : drives AWREADY/WREADY and the B response (burst target side)
// ----------------------------------------------------------------------------
interface video_axiw_arb_if;
    logic [3:0]   AWID;
    logic [31:0]  AWADDR;
    logic [7:0]   AWLEN;
    logic [2:0]   AWSIZE;
    logic [1:0]   AWBURST;
    logic         AWLOCK;
    logic [3:0]   AWCACHE;
    logic [2:0]   AWPROT;
    logic [3:0]   AWQOS;
    logic         AWVALID;
    logic         AWREADY;
    logic [511:0] WDATA;
    logic [63:0]  WSTRB;
    logic         WLAST;
    logic         WVALID;
    logic         WREADY;
    logic [3:0]   BID;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/video_axiw_arb.sv
// ----------------------------------------------------------------------------
// video_axiw_arb
//  2:1 AXI4 write-channel arbiter sharing the MIG1 AXI write port between two
//  video write controllers. One whole burst (AW + all W beats) is granted at a
//  time, round-robin or with fixed S0 priority. B responses are routed by BID
//  independently of the burst FSM. M_WLAST is regenerated from the latched AWLEN;
//  the masters' WLAST is ignored.
//  Ports:
//    CLK_MIG1_UI  MIG ui_clk (single clock domain)
//    XRST         asynchronous reset, active low
//    REG_ARB_MODE 0: round-robin, 1: fixed priority S0 > S1
//    REG_ARB_CLR  pulse, clears ARB_WDOG_ERR
//    S0, S1       slave-side write ports of the two video controllers
//    M            master-side write port towards the MIG AXI slot
//    ARB_GNT      one-hot current grant ([0]=S0, [1]=S1), 00 when idle
//    ARB_WDOG_ERR sticky watchdog abort flag
//  Optional feature: define VIDEO_AXIW_ARB_WDOG_EN to enable the stall watchdog
//  (P_WDOG_CYC stalled cycles in AVLD/DATA abandon the burst). Without it the
//  FSM only leaves DATA on the last beat and ARB_WDOG_ERR is tied 0.
// ----------------------------------------------------------------------------
module video_axiw_arb #(
    parameter logic [3:0]  P_S0_ID    = 4'h0,
    parameter logic [3:0]  P_S1_ID    = 4'h1,
    parameter logic [15:0] P_WDOG_CYC = 16'd4096
) (
    input  logic             CLK_MIG1_UI,
    input  logic             XRST,
    input  logic             REG_ARB_MODE,
    input  logic             REG_ARB_CLR,
    video_axiw_arb_if.slave  S0,
    video_axiw_arb_if.slave  S1,
    video_axiw_arb_if.master M,
    output logic [1:0]       ARB_GNT,
    output logic             ARB_WDOG_ERR
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_ARB  = 4'b0010,
        ST_AVLD = 4'b0100,
        ST_DATA = 4'b1000
    } state_t;

    state_t     state_q, state_nxt;
    logic       sel_q;      // 1: burst belongs to S1
    logic       rr_last_q;  // port served last (1 after reset so S0 is favoured)
    logic [1:0] gnt_q;
    logic [7:0] beat_q;
    logic [7:0] len_q;
    logic [1:0] req;
    logic       pick_s1;
    logic       aw_hs;
    logic       w_hs;
    logic       wdog_hit;
    logic       unused_wlast;

    assign req          = {S1.AWVALID, S0.AWVALID};
    assign unused_wlast = S0.WLAST ^ S1.WLAST;

    always_comb begin
        if (REG_ARB_MODE)
            pick_s1 = ~req[0];
        else if (&req)
            pick_s1 = ~rr_last_q;
        else
            pick_s1 = req[1];
    end

    // AW channel: fields always follow the selected port, VALID/READY only in AVLD
    assign M.AWID     = sel_q ? S1.AWID    : S0.AWID;
    assign M.AWADDR   = sel_q ? S1.AWADDR  : S0.AWADDR;
    assign M.AWLEN    = sel_q ? S1.AWLEN   : S0.AWLEN;
    assign M.AWSIZE   = sel_q ? S1.AWSIZE  : S0.AWSIZE;
    assign M.AWBURST  = sel_q ? S1.AWBURST : S0.AWBURST;
    assign M.AWLOCK   = sel_q ? S1.AWLOCK  : S0.AWLOCK;
    assign M.AWCACHE  = sel_q ? S1.AWCACHE : S0.AWCACHE;
    assign M.AWPROT   = sel_q ? S1.AWPROT  : S0.AWPROT;
    assign M.AWQOS    = sel_q ? S1.AWQOS   : S0.AWQOS;
    assign M.AWVALID  = (state_q == ST_AVLD) && (sel_q ? S1.AWVALID : S0.AWVALID);
    assign S0.AWREADY = (state_q == ST_AVLD) && !sel_q && M.AWREADY;
    assign S1.AWREADY = (state_q == ST_AVLD) &&  sel_q && M.AWREADY;

    // W channel: only in DATA; WLAST comes from the beat count, not the master
    assign M.WDATA    = sel_q ? S1.WDATA : S0.WDATA;
    assign M.WSTRB    = sel_q ? S1.WSTRB : S0.WSTRB;
    assign M.WLAST    = (state_q == ST_DATA) && (beat_q == len_q);
    assign M.WVALID   = (state_q == ST_DATA) && (sel_q ? S1.WVALID : S0.WVALID);
    assign S0.WREADY  = (state_q == ST_DATA) && !sel_q && M.WREADY;
    assign S1.WREADY  = (state_q == ST_DATA) &&  sel_q && M.WREADY;

    assign aw_hs   = M.AWVALID && M.AWREADY;
    assign w_hs    = M.WVALID && M.WREADY;
    assign ARB_GNT = gnt_q;

    // B routing is independent of the burst FSM; unknown IDs are drained
    assign S0.BID   = M.BID;
    assign S0.BRESP = M.BRESP;
    assign S1.BID   = M.BID;
    assign S1.BRESP = M.BRESP;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
        S0.BVALID = 1'b0;
        S1.BVALID = 1'b0;
        M.BREADY  = 1'b1;
        if (M.BID == P_S0_ID) begin
            S0.BVALID = M.BVALID;
            M.BREADY  = S0.BREADY;
        end else if (M.BID == P_S1_ID) begin
            S1.BVALID = M.BVALID;
            M.BREADY  = S1.BREADY;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (|req) state_nxt = ST_ARB;
            ST_ARB:  state_nxt = ST_AVLD;
            ST_AVLD: if (aw_hs) state_nxt = ST_DATA;
            ST_DATA: if (w_hs && M.WLAST) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (wdog_hit)
            state_nxt = ST_IDLE;
    end

    always_ff @(posedge CLK_MIG1_UI or negedge XRST) begin
        if (!XRST) begin
            state_q   <= ST_IDLE;
            sel_q     <= 1'b0;
            rr_last_q <= 1'b1;
            gnt_q     <= 2'b00;
            beat_q    <= 8'd0;
            len_q     <= 8'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= state_nxt;
            // Winner is decided in IDLE so a mode change never affects a burst in flight
            if (state_q == ST_IDLE && |req)
                sel_q <= pick_s1;
            if (state_nxt == ST_IDLE)
                gnt_q <= 2'b00;
            else if (state_q == ST_ARB)
                gnt_q <= sel_q ? 2'b10 : 2'b01;
            if (aw_hs) begin
                len_q  <= M.AWLEN;
                beat_q <= 8'd0;
            end else if (w_hs) begin
                beat_q <= beat_q + 8'd1;
            end
            if (w_hs && M.WLAST)
                rr_last_q <= sel_q;
        end
    end

`ifdef VIDEO_AXIW_ARB_WDOG_EN
    logic [15:0] wdog_cnt_q;
    logic        wdog_err_q;
    logic        wdog_run;

    // Any handshake proves progress and restarts the stall count
    assign wdog_run     = (state_q == ST_AVLD) || (state_q == ST_DATA);
    assign wdog_hit     = wdog_run && !aw_hs && !w_hs && (wdog_cnt_q == P_WDOG_CYC - 16'd1);
    assign ARB_WDOG_ERR = wdog_err_q;

    always_ff @(posedge CLK_MIG1_UI or negedge XRST) begin
        if (!XRST) begin
            wdog_cnt_q <= 16'd0;
            wdog_err_q <= 1'b0;
        end else begin
            if (!wdog_run || aw_hs || w_hs)
                wdog_cnt_q <= 16'd0;
            else
                wdog_cnt_q <= wdog_cnt_q + 16'd1;
            // A new abort outranks a simultaneous clear
            if (wdog_hit)
                wdog_err_q <= 1'b1;
            else if (REG_ARB_CLR)
                wdog_err_q <= 1'b0;
        end
    end
`else
    logic unused_wdog;

    assign wdog_hit     = 1'b0;
    assign ARB_WDOG_ERR = 1'b0;
    assign unused_wdog  = ^{REG_ARB_CLR, P_WDOG_CYC};
`endif

endmodule
